// File: rtl/matrix_page_scheduler_if.sv
// Bus between the image decoders, the matrix page scheduler and the matrix pins.
interface matrix_page_scheduler_if;
   logic       enable;
   logic       water_req;
   logic       irrigation_req;
   logic [6:0] water_col_2;
   logic [6:0] water_col_1;
   logic [6:0] water_col_0;
   logic [6:0] irrigation_col_2;
   logic [6:0] irrigation_col_1;
   logic [6:0] irrigation_col_0;
   logic [6:0] row;
   logic [2:0] col_en_n;
   logic       page;
   logic       frame_done;

   // Decoder/pin side: drives requests and images, observes matrix drive.
   modport master (
      output enable, water_req, irrigation_req,
      output water_col_2, water_col_1, water_col_0,
      output irrigation_col_2, irrigation_col_1, irrigation_col_0,
      input  row, col_en_n, page, frame_done
   );

   // Scheduler side.
   modport slave (
      input  enable, water_req, irrigation_req,
      input  water_col_2, water_col_1, water_col_0,
      input  irrigation_col_2, irrigation_col_1, irrigation_col_0,
      output row, col_en_n, page, frame_done
   );
endinterface

// File: rtl/matrix_page_scheduler.sv
// Time-multiplexed 7x3 LED matrix scanner alternating water / irrigation pages
// with a programmable per-page dwell and a one-slot blanking gap on page switch.
module matrix_page_scheduler #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DWELL_FRAMES = 4
) (
   input logic                    clock,
   input logic                    reset_n,
   matrix_page_scheduler_if.slave bus
);
   localparam int unsigned   PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned   DW        = $clog2(DWELL_FRAMES + 1);
   localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DwellMax  = DW'(DWELL_FRAMES);
   localparam logic [DW-1:0] DwellLast = DW'(DWELL_FRAMES - 1);

   typedef enum logic [1:0] {StIdle, StShowWater, StShowIrrig, StBlank} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    col_q, col_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [6:0]    row_q, row_d;
   logic [2:0]    col_en_n_q, col_en_n_d;
   logic          page_q, page_d;
   logic          show, tick, frame_end, dwell_hit, cur_req, oth_req;
   logic [6:0]    sel_col;

   assign show      = (state_q == StShowWater) || (state_q == StShowIrrig);
   assign tick      = (presc_q == PrescLast);
   assign frame_end = show && tick && (col_q == 2'd2);
   // This frame end brings the dwell count up to DWELL_FRAMES (or it is already saturated).
   assign dwell_hit = (dwell_q >= DwellLast);
   assign cur_req   = (state_q == StShowIrrig) ? bus.irrigation_req : bus.water_req;
   assign oth_req   = (state_q == StShowIrrig) ? bus.water_req : bus.irrigation_req;

   // State and scan counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         presc_q <= '0;
         col_q   <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         col_q   <= col_d;
         dwell_q <= dwell_d;
      end
   end

   // Next state and counters; page switches are decided only at frame ends.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      col_d   = col_q;
      dwell_d = dwell_q;
      if (!bus.enable) begin
         state_d = StIdle;
         presc_d = '0;
         col_d   = '0;
         dwell_d = '0;
      end else begin
         case (state_q)
            StShowWater, StShowIrrig: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
               end
               if (frame_end) begin
                  dwell_d = dwell_hit ? DwellMax : dwell_q + DW'(1);
                  if (oth_req && (!cur_req || dwell_hit)) begin
                     state_d = StBlank;
                     dwell_d = '0;
                  end else if (!cur_req && !oth_req) begin
                     state_d = StIdle;
                     dwell_d = '0;
                  end
               end
            end
            StBlank: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               col_d   = '0;
               dwell_d = '0;
               // page_q still names the page shown before the gap.
               if (tick) begin
                  state_d = page_q ? StShowWater : StShowIrrig;
               end
            end
            default: begin
               presc_d = '0;
               col_d   = '0;
               dwell_d = '0;
               if (bus.water_req) begin
                  state_d = StShowWater;
               end else if (bus.irrigation_req) begin
                  state_d = StShowIrrig;
               end
            end
         endcase
      end
   end

   // Output next-values: live column image of the shown page, blank otherwise.
   always_comb begin
      row_d      = '0;
      col_en_n_d = 3'b111;
      page_d     = page_q;
      if (state_q == StShowIrrig) begin
         case (col_q)
            2'd0:    sel_col = bus.irrigation_col_0;
            2'd1:    sel_col = bus.irrigation_col_1;
            default: sel_col = bus.irrigation_col_2;
         endcase
      end else begin
         case (col_q)
            2'd0:    sel_col = bus.water_col_0;
            2'd1:    sel_col = bus.water_col_1;
            default: sel_col = bus.water_col_2;
         endcase
      end
      if (bus.enable && show) begin
         row_d      = sel_col;
         col_en_n_d = ~(3'b001 << col_q);
         page_d     = (state_q == StShowIrrig);
      end
   end

   // Output registers; row and column enable change on the same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row_q      <= '0;
         col_en_n_q <= 3'b111;
         page_q     <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_en_n_q <= col_en_n_d;
         page_q     <= page_d;
      end
   end

   assign bus.row        = row_q;
   assign bus.col_en_n   = col_en_n_q;
   assign bus.page       = page_q;
   assign bus.frame_done = bus.enable && frame_end;
endmodule

// File: tb/tb_matrix_page_scheduler.sv
// Bench for matrix_page_scheduler with SCAN_DIV=4, DWELL_FRAMES=2.
module tb_matrix_page_scheduler;
   localparam int SD = 4;
   localparam int DF = 2;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   matrix_page_scheduler_if bus_if ();

   matrix_page_scheduler #(
      .SCAN_DIV    (SD),
      .DWELL_FRAMES(DF)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int fd_count;
   int blank_count;

   // Model: mode 0 idle, 1 water, 2 irrigation, 3 blank; m_t = clocks since mode entry.
   int         m_mode;
   int         m_t;
   int         m_frames;
   int         m_shown;
   logic [6:0] e_row;
   logic [2:0] e_col_en_n;
   logic       e_page;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] img(input int p, input int c);
      if (p == 1) return (c == 0) ? bus_if.water_col_0 :
                         (c == 1) ? bus_if.water_col_1 : bus_if.water_col_2;
      return (c == 0) ? bus_if.irrigation_col_0 :
             (c == 1) ? bus_if.irrigation_col_1 : bus_if.irrigation_col_2;
   endfunction

   function automatic bit m_show();
      return (m_mode == 1) || (m_mode == 2);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_t = 0; m_frames = 0; m_shown = 1;
      e_row = '0; e_col_en_n = 3'b111; e_page = 1'b0;
   endtask

   task automatic enter(input int p);
      m_mode = p; m_shown = p; m_t = 0; m_frames = 0;
   endtask

   // Advance the model across one rising edge, using inputs seen at that edge.
   task automatic model_step();
      int col;
      bit tick, fe, cur, oth;
      if (!reset_n) begin
         model_reset();
         return;
      end
      col  = (m_t / SD) % 3;
      tick = (m_t % SD) == SD - 1;
      fe   = m_show() && tick && (col == 2);
      if (bus_if.enable && m_show()) begin
         e_col_en_n      = 3'b111;
         e_col_en_n[col] = 1'b0;
         e_row           = img(m_mode, col);
         e_page          = (m_mode == 2);
      end else begin
         e_col_en_n = 3'b111;
         e_row      = '0;
      end
      if (!bus_if.enable) begin
         m_mode = 0; m_t = 0;
      end else if (m_mode == 0) begin
         if (bus_if.water_req) enter(1);
         else if (bus_if.irrigation_req) enter(2);
      end else if (m_mode == 3) begin
         if (m_t == SD - 1) enter((m_shown == 1) ? 2 : 1);
         else m_t++;
      end else begin
         cur = (m_mode == 1) ? bus_if.water_req : bus_if.irrigation_req;
         oth = (m_mode == 1) ? bus_if.irrigation_req : bus_if.water_req;
         if (fe) begin
            m_frames = (m_frames + 1 > DF) ? DF : m_frames + 1;
            if (oth && (!cur || m_frames >= DF)) begin
               m_mode = 3; m_t = 0;
            end else if (!cur && !oth) begin
               m_mode = 0; m_t = 0;
            end else begin
               m_t++;
            end
         end else begin
            m_t++;
         end
      end
   endtask

   // Per-cycle comparison of every output against the model.
   task automatic compare();
      logic e_fd;
      e_fd = bus_if.enable && m_show() && ((m_t % SD) == SD - 1) && (((m_t / SD) % 3) == 2);
      chk("row", bus_if.row, e_row);
      chk("col_en_n", bus_if.col_en_n, e_col_en_n);
      chk("page", bus_if.page, e_page);
      chk("frame_done", bus_if.frame_done, e_fd);
      chk("onehot", ($countones(~bus_if.col_en_n) <= 1), 1);
      if (bus_if.frame_done) fd_count++;
      if (bus_if.col_en_n == 3'b111) blank_count++;
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      cyc++;
      compare();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic set_in(input logic en, input logic w, input logic i);
      bus_if.enable = en; bus_if.water_req = w; bus_if.irrigation_req = i;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      cyc = -1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (3) step();
      release_reset();
   endtask

   task automatic lit_out(input string name, input logic [2:0] c, input logic [6:0] r,
                          input logic p);
      chk({name, "_col"}, bus_if.col_en_n, c);
      chk({name, "_row"}, bus_if.row, r);
      chk({name, "_page"}, bus_if.page, p);
   endtask

   initial begin
      bus_if.water_col_0 = 7'h01; bus_if.water_col_1 = 7'h02; bus_if.water_col_2 = 7'h04;
      bus_if.irrigation_col_0 = 7'h7F; bus_if.irrigation_col_1 = 7'h7F;
      bus_if.irrigation_col_2 = 7'h7F;
      set_in(1'b1, 1'b1, 1'b0);
      #1;

      // Water only: column scan, frame pulse period, page stays 0.
      do_reset();
      run_to(1);  lit_out("w_c0", 3'b110, 7'h01, 1'b0);
      run_to(5);  lit_out("w_c1", 3'b101, 7'h02, 1'b0);
      run_to(9);  lit_out("w_c2", 3'b011, 7'h04, 1'b0);
      run_to(11); chk("w_fd_first", bus_if.frame_done, 1);
      run_to(12); chk("w_fd_single", bus_if.frame_done, 0);
      fd_count = 0;
      run_to(47); chk("w_fd_count", fd_count, 3);
      chk("w_page_hold", bus_if.page, 0);

      // Both requests from idle: water first, dwell 2 frames, blank gap, irrigation, back.
      set_in(1'b1, 1'b1, 1'b1);
      do_reset();
      run_to(1);  lit_out("b_first", 3'b110, 7'h01, 1'b0);
      blank_count = 0;
      run_to(12);
      blank_count = 0;
      run_to(26); lit_out("b_gap", 3'b111, 7'h00, 1'b0);
      run_to(29); lit_out("b_irr", 3'b110, 7'h7F, 1'b1);
      run_to(40); chk("b_gap_len", blank_count, 4);
      run_to(57); lit_out("b_back", 3'b110, 7'h01, 1'b0);

      // Water drops mid first frame: switch at frame end despite dwell below limit.
      set_in(1'b1, 1'b1, 1'b0);
      do_reset();
      run_to(5);
      set_in(1'b1, 1'b0, 1'b1);
      run_to(12); lit_out("d_last", 3'b011, 7'h04, 1'b0);
      run_to(14); lit_out("d_gap", 3'b111, 7'h00, 1'b0);
      run_to(17); lit_out("d_irr", 3'b110, 7'h7F, 1'b1);

      // Enable dropped in column 2 slot, then restored.
      set_in(1'b1, 1'b1, 1'b0);
      do_reset();
      run_to(10);
      set_in(1'b0, 1'b1, 1'b0);
      fd_count = 0;
      run_to(11); lit_out("e_off", 3'b111, 7'h00, 1'b0);
      run_to(20); chk("e_no_fd", fd_count, 0);
      set_in(1'b1, 1'b1, 1'b0);
      run_to(22); lit_out("e_on", 3'b110, 7'h01, 1'b0);
      run_to(25); lit_out("e_slot_end", 3'b110, 7'h01, 1'b0);
      run_to(26); lit_out("e_c1", 3'b101, 7'h02, 1'b0);

      // Asynchronous reset while on the irrigation page.
      set_in(1'b1, 1'b0, 1'b1);
      do_reset();
      run_to(6);  lit_out("r_irr", 3'b101, 7'h7F, 1'b1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      lit_out("r_async", 3'b111, 7'h00, 1'b0);
      chk("r_async_fd", bus_if.frame_done, 0);
      repeat (2) step();
      set_in(1'b1, 1'b1, 1'b0);
      release_reset();
      run_to(1);  lit_out("r_restart", 3'b110, 7'h01, 1'b0);
      run_to(5);  lit_out("r_c1", 3'b101, 7'h02, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/matrix_page_scheduler.md
Name: matrix_page_scheduler

Overview:
- Time-multiplexed controller for the 7-row x 3-column LED matrix.
- Alternates between the water-level page and the irrigation page, with a programmable dwell per page and a one-slot blanking gap on each page switch.
- Scans one column at a time and drives row data plus an active-low one-hot column enable.
- Sits between the water/irrigation image decoders and the matrix pins; replaces clock-level page selection.

Parameters:
- SCAN_DIV, 1000: clocks per column slot; legal range >=2.
- DWELL_FRAMES, 4: full 3-column frames shown per page before a switch is allowed; legal range >=1.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  high runs the scheduler; low forces IDLE.
- water_req  input  1  water page is valid for display.
- irrigation_req  input  1  irrigation page is valid for display.
- water_col_2, water_col_1, water_col_0  input  7 each  water page column images; bit i = row i lit.
- irrigation_col_2, irrigation_col_1, irrigation_col_0  input  7 each  irrigation page column images.
- row  output  7  row data for the currently enabled column; active-high.
- col_en_n  output  3  one-hot active-low column enable; bit k = column k.
- page  output  1  0 = water shown, 1 = irrigation shown; holds its last value in IDLE/BLANK.
- frame_done  output  1  one-clock pulse when column 2's slot ends, in SHOW states only.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, prescaler=0, col_idx=0, dwell=0, row=7'b0, col_en_n=3'b111, page=0, frame_done=0.
- Prescaler:
  - counts 0..SCAN_DIV-1 whenever state != IDLE.
  - tick = (prescaler==SCAN_DIV-1); wraps to 0 on tick.
  - width $clog2(SCAN_DIV).
- col_idx: advances 0->1->2->0 on tick. The wrap 2->0 in a SHOW state is a frame end: frame_done=1 for that single clock.
- dwell: counts frame ends in the current page, saturating at DWELL_FRAMES; cleared on every page entry. Width $clog2(DWELL_FRAMES+1).
- States:
  - IDLE -> SHOW_WATER when enable && water_req; else -> SHOW_IRRIG when enable && irrigation_req. Water has priority. Entry clears prescaler, col_idx and dwell.
  - SHOW_WATER / SHOW_IRRIG, at each frame end:
    - If the current page's req is low and the other page's req is high -> BLANK.
    - If dwell reaches DWELL_FRAMES (counting this frame) and the other page's req is high -> BLANK.
    - If neither req is high -> IDLE.
    - Otherwise stay; dwell saturates.
  - BLANK: lasts exactly one column slot (SCAN_DIV clocks). Then enter the other page at col_idx=0 with dwell=0, and toggle page.
- Switching occurs only at frame ends; a req change mid-frame has no effect until the frame end.
- enable=0 in any state -> IDLE on the next clock; outputs blank on that same edge.
- Output registers, 1-clock latency from state/col_idx:
  - In SHOW states: col_en_n = ~(3'b001 << col_idx); row = selected page's column col_idx, sampled every clock (live data passes through with 1-clock latency).
  - In IDLE and BLANK: row=0, col_en_n=3'b111.
- Invariants:
  - At most one col_en_n bit is low at any time.
  - row and col_en_n update on the same edge, so there are no cross-column glitches.

Test Plan:
- SCAN_DIV=4, DWELL_FRAMES=2, water_req=1, irrigation_req=0, water_col_0=7'h01, water_col_1=7'h02, water_col_2=7'h04, after reset release -> col_en_n cycles 110,101,011 every 4 clocks; row follows 01,02,04; frame_done pulses every 12 clocks; page stays 0 indefinitely.
- Same setup, then irrigation_req=1 with irrigation cols 7'h7F -> after 2 water frames: 4 clocks of col_en_n=111, row=0; then page=1, row=7F; after 2 more frames, blank again, then back to page 0.
- Both reqs rise together from IDLE -> water shown first (page=0).
- water_req drops mid-frame while irrigation_req=1 -> current frame completes, then BLANK, then irrigation, regardless of dwell count.
- enable dropped mid-slot -> next clock col_en_n=111, row=0, frame_done never pulses; on re-enable, scan restarts at column 0 with a full-length slot.
- reset_n asserted mid-scan (asynchronous, not clock-aligned) -> outputs reach reset values immediately without waiting for a clock edge; after release, scan restarts at column 0 of the water page.
